// File: rtl/cacheline_burst_adapter.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_burst_adapter
// Description : Bridges a 256-bit cacheline interface to a 64-bit, 4-beat
//               memory burst interface. Read misses collect four beats into
//               line_o; write-backs split line_i into four beats on burst_o.
//               States: IDLE -> RD/WR -> DONE -> IDLE.
// Ports       : clk, rst (sync, active-high)
//               cache side : line_i, address_i, read_i, write_i -> line_o, resp_o
//               memory side: burst_i, resp_i -> burst_o, address_o, read_o, write_o
//               error_o    : sticky watchdog flag
// Options     : CLA_TIMEOUT_EN - enables a stall watchdog that sets error_o
//               after TIMEOUT_CYCLES consecutive stalled RD/WR cycles.
//               When undefined, error_o is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_burst_adapter #(
    parameter int S_LINE         = 256,
    parameter int S_BURST        = 64,
    parameter int NUM_BEATS      = S_LINE / S_BURST,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int S_OFFSET       = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [S_LINE-1:0]  line_i,
    output logic [S_LINE-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [S_BURST-1:0] burst_i,
    output logic [S_BURST-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i,
    output logic               error_o
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_rd   = 2'd1;
    localparam logic [1:0] c_wr   = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    localparam int               c_cnt_w = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NUM_BEATS - 1);

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [S_LINE-1:0]  r_line;
    logic [S_LINE-1:0]  r_wbuf;
    logic [31:0]        r_addr;

    // The line offset bits never reach memory; keep them visibly consumed.
    logic w_unused;
    assign w_unused = &{1'b0, address_i[S_OFFSET-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_line  <= '0;
            r_wbuf  <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    // Write wins if the controller raises both requests.
                    if (write_i) begin
                        r_wbuf  <= line_i;
                        r_addr  <= {address_i[31:S_OFFSET], {S_OFFSET{1'b0}}};
                        r_cnt   <= '0;
                        r_state <= c_wr;
                    end else if (read_i) begin
                        r_addr  <= {address_i[31:S_OFFSET], {S_OFFSET{1'b0}}};
                        r_cnt   <= '0;
                        r_state <= c_rd;
                    end
                end
                c_rd: begin
                    if (resp_i) begin
                        r_line[S_BURST*int'(r_cnt) +: S_BURST] <= burst_i;
                        // Counter parks on the last beat rather than wrapping.
                        if (r_cnt == c_last) begin
                            r_state <= c_done;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_wr: begin
                    if (resp_i) begin
                        if (r_cnt == c_last) begin
                            r_state <= c_done;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign line_o    = r_line;
    assign address_o = r_addr;
    assign read_o    = (r_state == c_rd);
    assign write_o   = (r_state == c_wr);
    assign resp_o    = (r_state == c_done);
    assign burst_o   = (r_state == c_wr) ? r_wbuf[S_BURST*int'(r_cnt) +: S_BURST]
                                         : '0;

`ifdef CLA_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_to_w-1:0] r_stall;
    logic              r_error;
    logic              w_busy;

    assign w_busy = (r_state == c_rd) || (r_state == c_wr);

    // Counts consecutive stalled busy cycles; the flag is raised on the edge
    // that completes the TIMEOUT_CYCLES-th stall and only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
            r_error <= 1'b0;
        end else begin
            if (!w_busy || resp_i) begin
                r_stall <= '0;
            end else if (r_stall != c_to_w'(TIMEOUT_CYCLES)) begin
                r_stall <= r_stall + 1'b1;
            end
            if (w_busy && !resp_i && (r_stall == c_to_w'(TIMEOUT_CYCLES - 1))) begin
                r_error <= 1'b1;
            end
        end
    end

    assign error_o = r_error;
`else
    assign error_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cacheline_burst_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_burst_adapter
// Description : Directed self-checking bench for cacheline_burst_adapter.
//               Inputs change 1 ns after a rising edge; outputs are sampled
//               at the same point, before the inputs are updated.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_burst_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;
    logic         error_o;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef CLA_TIMEOUT_EN
    localparam logic c_exp_err = 1'b1;
    localparam int   c_timeout = 8;
`else
    localparam logic c_exp_err = 1'b0;
    localparam int   c_timeout = 1024;
`endif

    cacheline_burst_adapter #(.TIMEOUT_CYCLES(c_timeout)) dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i),
        .error_o   (error_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        tick(); tick();
        n_checks++;
        if ({line_o, burst_o, address_o, read_o, write_o, resp_o, error_o} !== '0)
            $display("FAIL reset_outputs: got line=%h burst=%h addr=%h r=%b w=%b resp=%b err=%b, want all 0",
                     line_o, burst_o, address_o, read_o, write_o, resp_o, error_o);
        else n_pass++;
        rst = 1'b0;
        resp_i = 1'b1;  // ignored in IDLE
        tick();
        n_checks++;
        if ({read_o, write_o, resp_o, address_o} !== '0)
            $display("FAIL idle_after_reset: got r=%b w=%b resp=%b addr=%h, want 0", read_o, write_o, resp_o, address_o);
        else n_pass++;
        resp_i = 1'b0;
    endtask

    task automatic test_read_zero_wait();
        logic [63:0] beats [4];
        beats[0] = {16{4'h1}}; beats[1] = {16{4'h2}}; beats[2] = {16{4'h3}}; beats[3] = {16{4'h4}};
        address_i = 32'h0000_1234; read_i = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({read_o, write_o, resp_o, address_o} !== {3'b100, 32'h0000_1220})
                $display("FAIL read_beat%0d: got r=%b w=%b resp=%b addr=%h, want r=1 w=0 resp=0 addr=00001220",
                         k, read_o, write_o, resp_o, address_o);
            else n_pass++;
            burst_i = beats[k]; resp_i = 1'b1;
            tick();
        end
        n_checks++;
        if ({resp_o, read_o} !== 2'b10)
            $display("FAIL read_done: got resp=%b r=%b, want resp=1 r=0", resp_o, read_o);
        else n_pass++;
        n_checks++;
        if (line_o !== {beats[3], beats[2], beats[1], beats[0]})
            $display("FAIL read_line: got %h, want %h", line_o, {beats[3], beats[2], beats[1], beats[0]});
        else n_pass++;
        read_i = 1'b0; resp_i = 1'b0; burst_i = '0;
        tick();
        n_checks++;
        if ({resp_o, line_o} !== {1'b0, beats[3], beats[2], beats[1], beats[0]})
            $display("FAIL read_after: got resp=%b line=%h, want resp=0 line stable", resp_o, line_o);
        else n_pass++;
    endtask

    task automatic test_write_stalls();
        logic [63:0] exp_b [7];
        logic        pat   [7];
        exp_b[0] = {16{4'hA}}; exp_b[1] = {16{4'hB}}; exp_b[2] = {16{4'hB}}; exp_b[3] = {16{4'hB}};
        exp_b[4] = {16{4'hC}}; exp_b[5] = {16{4'hD}}; exp_b[6] = {16{4'hD}};
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
        line_i = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        address_i = 32'h0000_8001; write_i = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if ({write_o, read_o, resp_o, burst_o, address_o} !== {3'b100, exp_b[i], 32'h0000_8000})
                $display("FAIL write_cycle%0d: got w=%b r=%b resp=%b burst=%h addr=%h, want w=1 r=0 resp=0 burst=%h addr=00008000",
                         i, write_o, read_o, resp_o, burst_o, address_o, exp_b[i]);
            else n_pass++;
            resp_i = pat[i];
            tick();
        end
        n_checks++;
        if ({resp_o, write_o} !== 2'b10)
            $display("FAIL write_done: got resp=%b w=%b, want resp=1 w=0", resp_o, write_o);
        else n_pass++;
        write_i = 1'b0; resp_i = 1'b0;
        tick();
        n_checks++;
        if ({resp_o, write_o, burst_o} !== '0)
            $display("FAIL write_after: got resp=%b w=%b burst=%h, want 0", resp_o, write_o, burst_o);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [255:0] prev_line;
        prev_line = line_o;
        line_i = {4{64'hFEED_0000_BEEF_1111}};
        address_i = 32'h0000_0040; read_i = 1'b1; write_i = 1'b1;
        burst_i = 64'hDEAD_DEAD_DEAD_DEAD;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({write_o, read_o, burst_o} !== {2'b10, 64'hFEED_0000_BEEF_1111})
                $display("FAIL both_req%0d: got w=%b r=%b burst=%h, want w=1 r=0 burst=feed0000beef1111",
                         k, write_o, read_o, burst_o);
            else n_pass++;
            resp_i = 1'b1;
            tick();
        end
        n_checks++;
        if ({resp_o, read_o, line_o} !== {2'b10, prev_line})
            $display("FAIL both_done: got resp=%b r=%b line=%h, want resp=1 r=0 line unchanged",
                     resp_o, read_o, line_o);
        else n_pass++;
        read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        logic [63:0] beats [4];
        beats[0] = {16{4'h5}}; beats[1] = {16{4'h6}}; beats[2] = {16{4'h7}}; beats[3] = {16{4'h8}};
        address_i = 32'h0000_5678; read_i = 1'b1;
        tick();
        burst_i = {16{4'h9}}; resp_i = 1'b1; tick();
        burst_i = {16{4'hE}}; tick();
        rst = 1'b1; read_i = 1'b0; resp_i = 1'b0;
        tick();
        n_checks++;
        if ({line_o, burst_o, address_o, read_o, write_o, resp_o} !== '0)
            $display("FAIL mid_reset: got line=%h addr=%h r=%b w=%b resp=%b, want all 0",
                     line_o, address_o, read_o, write_o, resp_o);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if ({resp_o, read_o} !== 2'b00)
            $display("FAIL mid_reset_idle: got resp=%b r=%b, want 0 0", resp_o, read_o);
        else n_pass++;
        address_i = 32'h0000_9ABC; read_i = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            burst_i = beats[k]; resp_i = 1'b1;
            tick();
        end
        n_checks++;
        if ({resp_o, address_o, line_o} !== {1'b1, 32'h0000_9AA0, beats[3], beats[2], beats[1], beats[0]})
            $display("FAIL fresh_read: got resp=%b addr=%h line=%h, want resp=1 addr=00009aa0 line=%h",
                     resp_o, address_o, line_o, {beats[3], beats[2], beats[1], beats[0]});
        else n_pass++;
        read_i = 1'b0; resp_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int n_resp = 0;
        int n_rd   = 0;
        int n_wr   = 0;
        int bad_addr = 0;
        line_i = {4{64'h0F0F_0F0F_0F0F_0F0F}};
        address_i = 32'h0000_0040; write_i = 1'b1; read_i = 1'b0;
        burst_i = 64'h0123_4567_89AB_CDEF; resp_i = 1'b1;  // held high, also in IDLE/DONE
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (read_o) begin
                n_rd++;
                if (address_o !== 32'h0000_3FE0) bad_addr++;
            end
            if (write_o) n_wr++;
            if (resp_o) begin
                n_resp++;
                if (write_i) begin
                    write_i = 1'b0; read_i = 1'b1; address_i = 32'h0000_3FFF;
                end else begin
                    read_i = 1'b0;
                end
            end
        end
        n_checks++;
        if (n_resp !== 2)
            $display("FAIL b2b_resp_count: got %0d, want 2", n_resp);
        else n_pass++;
        n_checks++;
        if ({n_rd, n_wr, bad_addr} !== {32'd4, 32'd4, 32'd0})
            $display("FAIL b2b_beats: got rd=%0d wr=%0d bad_addr=%0d, want 4 4 0", n_rd, n_wr, bad_addr);
        else n_pass++;
        n_checks++;
        if (line_o !== {4{64'h0123_4567_89AB_CDEF}})
            $display("FAIL b2b_line: got %h, want 4x0123456789abcdef", line_o);
        else n_pass++;
        resp_i = 1'b0; read_i = 1'b0; write_i = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        address_i = 32'h0000_0100; read_i = 1'b1; resp_i = 1'b0;
        tick();
        for (int s = 1; s <= 8; s++) begin
            n_checks++;
            if ({read_o, error_o} !== 2'b10)
                $display("FAIL stall_cycle%0d: got r=%b err=%b, want r=1 err=0", s, read_o, error_o);
            else n_pass++;
            tick();
        end
        n_checks++;
        if ({read_o, error_o} !== {1'b1, c_exp_err})
            $display("FAIL timeout_flag: got r=%b err=%b, want r=1 err=%b", read_o, error_o, c_exp_err);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            burst_i = {8{8'h10 + 8'(k)}}; resp_i = 1'b1;
            tick();
        end
        n_checks++;
        if ({resp_o, error_o, line_o} !== {1'b1, c_exp_err, {8{8'h13}}, {8{8'h12}}, {8{8'h11}}, {8{8'h10}}})
            $display("FAIL timeout_complete: got resp=%b err=%b line=%h, want resp=1 err=%b",
                     resp_o, error_o, line_o, c_exp_err);
        else n_pass++;
        read_i = 1'b0; resp_i = 1'b0;
        tick(); tick();
        n_checks++;
        if (error_o !== c_exp_err)
            $display("FAIL timeout_sticky: got err=%b, want %b", error_o, c_exp_err);
        else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_stalls();
        test_simultaneous();
        test_reset_mid_read();
        test_back_to_back();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cacheline_burst_adapter.md
Name: cacheline_burst_adapter

Overview:
- Sits between the cache datapath/controller and physical memory.
- Converts one 256-bit cacheline transfer on the cache side into a 4-beat, 64-bit burst on the memory side, and back.
- Read misses: collects four 64-bit beats into a 256-bit line and returns it to the cache as pmem_rdata.
- Write-backs: splits the cache's pmem_wdata into four beats.

Parameters:
- s_line, 256, cacheline width in bits.
- s_burst, 64, memory beat width in bits.
- num_beats, s_line/s_burst (4), beats per line.
- s_offset, 5, line-offset bits cleared on the outgoing address.
- timeout_cycles, 1024, watchdog limit; used only with CLA_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- line_i  in  256  line to write back (cache pmem_wdata).
- line_o  out  256  assembled read line (cache pmem_rdata).
- address_i  in  32  cache pmem_address.
- read_i  in  1  cache line-read request.
- write_i  in  1  cache line-write request.
- resp_o  out  1  transfer complete, one-cycle pulse.
- burst_i  in  64  memory read beat.
- burst_o  out  64  memory write beat.
- address_o  out  32  line-aligned memory address.
- read_o  out  1  memory read request.
- write_o  out  1  memory write request.
- resp_i  in  1  memory beat valid/accepted.
- error_o  out  1  sticky watchdog flag.

Behaviour:
- Single clock clk; synchronous active-high reset rst. All outputs are registered or decoded from state.
- Reset values: state IDLE, beat counter 0, line_o 0, burst_o 0, address_o 0, read_o 0, write_o 0, resp_o 0, error_o 0.
- Reset asserted mid-transfer aborts it immediately; no resp_o is issued.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - read_i and write_i are sampled only in this state.
  - write_i=1: latch line_i into the write buffer and {address_i[31:s_offset], s_offset zeros} into address_o; clear counter; go to WR.
  - Else read_i=1: latch the address; clear counter; go to RD.
  - Both asserted is illegal from the controller. The adapter services the write and drops the read.
- RD:
  - read_o=1.
  - Each cycle with resp_i=1: line_o[64*cnt +: 64] <= burst_i; cnt++.
  - Cycles with resp_i=0 hold everything.
  - On the beat with cnt==num_beats-1 and resp_i=1, go to DONE. read_o drops in DONE.
- WR:
  - write_o=1; burst_o = wbuf[64*cnt +: 64], beat 0 first.
  - Each resp_i=1 advances cnt.
  - On the last accepted beat, go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle; read_o=write_o=0; go to IDLE.
  - line_o is stable from DONE until the next read's first beat.
- Minimum latency with zero-wait memory:
  - Request seen in IDLE at cycle 0.
  - read_o/write_o high cycles 1-4.
  - resp_o at cycle 5.
- Controller contract: hold the request until resp_o, then drop it on the next edge. Requests asserted while not in IDLE are ignored.
- resp_i in IDLE or DONE is ignored. Beat counter is 2 bits and never wraps inside a transfer.
- address_o is held constant for the whole transfer. Low s_offset bits are always 0.

Optional Feature:
- Macro: CLA_TIMEOUT_EN.
- Defined:
  - A cycle counter counts consecutive RD/WR cycles with resp_i=0 and resets on any resp_i=1 or on leaving RD/WR.
  - When it reaches timeout_cycles, error_o is set and stays 1 until rst.
  - The transfer itself continues unchanged.
- Not defined: no counter logic; error_o tied to 0.

Test Plan:
- Read, zero-wait: address_i=0x0000_1234, read_i, burst_i beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with resp_i high 4 cycles.
  -> address_o=0x0000_1220; read_o high exactly 4 cycles; resp_o pulses at cycle 5; line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write with stalls: line_i = words W3..W0 = 0xD..,0xC..,0xB..,0xA..; resp_i pattern 1,0,0,1,1,0,1.
  -> burst_o shows W0, W1 (held 3 cycles), W2, W3 (held 2 cycles); write_o drops after the 4th accepted beat; single resp_o.
- Simultaneous read_i=write_i=1 in IDLE -> WR transfer only; read_o never asserts.
- Reset mid-read after 2 beats -> next cycle all outputs 0, state IDLE. A following read returns the correct fresh line with no stale words.
- Back-to-back write then read, request dropped on resp_o -> exactly two resp_o pulses; read address_o matches the second request.
- CLA_TIMEOUT_EN with timeout_cycles=8: read with resp_i held 0 for 8 cycles -> error_o=1 from cycle 9 and stays set. Beats then complete normally with resp_o. Without the macro, error_o stays 0.
